// File: rtl/morse_rx_decoder_if.sv
// Purpose : groups the keyed-line sample inputs and the decoded-character
//           outputs of morse_rx_decoder into one bundle.
// Ports   : tick, morse_in (toward decoder); salida[7:0], valid, err (from decoder).
//           master = line/consumer side, slave = decoder side.
interface morse_rx_decoder_if;
  logic       tick;
  logic       morse_in;
  logic [7:0] salida;
  logic       valid;
  logic       err;

  modport master (output tick, output morse_in,
                  input  salida, input valid, input err);
  modport slave  (input  tick, input morse_in,
                  output salida, output valid, output err);
endinterface

// File: rtl/morse_rx_decoder.sv
// Purpose : measures mark/space durations of a keyed line in tick units,
//           classifies dots/dashes, assembles up to 5 symbols and decodes
//           the character to ASCII (letters, digits; '?' with err on error).
// Ports   : CLK, RST (async active-low), bus (slave modport of
//           morse_rx_decoder_if): tick, morse_in in; salida, valid, err out.
// Config  : MORSE_RX_WORDGAP_EN enables emission of ' ' at a word gap.
//           Latency: valid is registered, one cycle after the completing tick.
module morse_rx_decoder #(
  parameter int UNIT = 4
) (
  input  logic               CLK,
  input  logic               RST,
  morse_rx_decoder_if.slave  bus
);

  localparam logic [7:0] LIM_DOT  = 8'(2 * UNIT);  // marks shorter than this are dots
  localparam logic [7:0] LIM_BAD  = 8'(8 * UNIT);  // over-long mark threshold
  localparam logic [7:0] LIM_CHAR = 8'(2 * UNIT);  // inter-character gap
  localparam logic [7:0] LIM_WORD = 8'(5 * UNIT);  // word gap, back to IDLE

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [2:0] r_len;
  logic [4:0] r_pattern;
  logic       r_bad;
  logic [7:0] r_salida;
  logic       r_valid;
  logic       r_err;
`ifdef MORSE_RX_WORDGAP_EN
  logic       r_emitted;  // a character went out since the last word gap
`endif

  logic [7:0] w_cnt_inc;
  logic       w_dash;
  logic [8:0] w_dec;

  // Pattern is right-aligned: the first symbol sits at bit len-1.
  // Returns {err, ascii}.
  function automatic logic [8:0] f_decode(input logic [2:0] len,
                                          input logic [4:0] pat,
                                          input logic       bad);
    logic [8:0] res;
    res = {1'b1, 8'h3F};
    if (!bad) begin
      case ({len, pat})
        {3'd2, 5'b00001}: res = {1'b0, 8'h41}; // A .-
        {3'd4, 5'b01000}: res = {1'b0, 8'h42}; // B -...
        {3'd4, 5'b01010}: res = {1'b0, 8'h43}; // C -.-.
        {3'd3, 5'b00100}: res = {1'b0, 8'h44}; // D -..
        {3'd1, 5'b00000}: res = {1'b0, 8'h45}; // E .
        {3'd4, 5'b00010}: res = {1'b0, 8'h46}; // F ..-.
        {3'd3, 5'b00110}: res = {1'b0, 8'h47}; // G --.
        {3'd4, 5'b00000}: res = {1'b0, 8'h48}; // H ....
        {3'd2, 5'b00000}: res = {1'b0, 8'h49}; // I ..
        {3'd4, 5'b00111}: res = {1'b0, 8'h4A}; // J .---
        {3'd3, 5'b00101}: res = {1'b0, 8'h4B}; // K -.-
        {3'd4, 5'b00100}: res = {1'b0, 8'h4C}; // L .-..
        {3'd2, 5'b00011}: res = {1'b0, 8'h4D}; // M --
        {3'd2, 5'b00010}: res = {1'b0, 8'h4E}; // N -.
        {3'd3, 5'b00111}: res = {1'b0, 8'h4F}; // O ---
        {3'd4, 5'b00110}: res = {1'b0, 8'h50}; // P .--.
        {3'd4, 5'b01101}: res = {1'b0, 8'h51}; // Q --.-
        {3'd3, 5'b00010}: res = {1'b0, 8'h52}; // R .-.
        {3'd3, 5'b00000}: res = {1'b0, 8'h53}; // S ...
        {3'd1, 5'b00001}: res = {1'b0, 8'h54}; // T -
        {3'd3, 5'b00001}: res = {1'b0, 8'h55}; // U ..-
        {3'd4, 5'b00001}: res = {1'b0, 8'h56}; // V ...-
        {3'd3, 5'b00011}: res = {1'b0, 8'h57}; // W .--
        {3'd4, 5'b01001}: res = {1'b0, 8'h58}; // X -..-
        {3'd4, 5'b01011}: res = {1'b0, 8'h59}; // Y -.--
        {3'd4, 5'b01100}: res = {1'b0, 8'h5A}; // Z --..
        {3'd5, 5'b11111}: res = {1'b0, 8'h30}; // 0
        {3'd5, 5'b01111}: res = {1'b0, 8'h31}; // 1
        {3'd5, 5'b00111}: res = {1'b0, 8'h32}; // 2
        {3'd5, 5'b00011}: res = {1'b0, 8'h33}; // 3
        {3'd5, 5'b00001}: res = {1'b0, 8'h34}; // 4
        {3'd5, 5'b00000}: res = {1'b0, 8'h35}; // 5
        {3'd5, 5'b10000}: res = {1'b0, 8'h36}; // 6
        {3'd5, 5'b11000}: res = {1'b0, 8'h37}; // 7
        {3'd5, 5'b11100}: res = {1'b0, 8'h38}; // 8
        {3'd5, 5'b11110}: res = {1'b0, 8'h39}; // 9
        default:          res = {1'b1, 8'h3F};
      endcase
    end
    return res;
  endfunction

  // Saturating increment so an endless mark parks at 255.
  assign w_cnt_inc = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;
  assign w_dash    = (r_cnt >= LIM_DOT);
  assign w_dec     = f_decode(r_len, r_pattern, r_bad);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_len     <= 3'd0;
      r_pattern <= 5'd0;
      r_bad     <= 1'b0;
      r_salida  <= 8'h00;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
`ifdef MORSE_RX_WORDGAP_EN
      r_emitted <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      if (bus.tick) begin
        case (r_state)
          IDLE: begin
            if (bus.morse_in) begin
              r_state <= MARK;
              r_cnt   <= 8'd1;
            end
          end

          MARK: begin
            if (bus.morse_in) begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc >= LIM_BAD) r_bad <= 1'b1;
            end else begin
              // Mark released: classify on its full length.
              if (r_len == 3'd5) begin
                r_bad <= 1'b1;
              end else begin
                r_pattern <= {r_pattern[3:0], w_dash};
                r_len     <= r_len + 3'd1;
              end
              r_state <= SPACE;
              r_cnt   <= 8'd1;
            end
          end

          SPACE: begin
            if (bus.morse_in) begin
              r_state <= MARK;
              r_cnt   <= 8'd1;
            end else begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == LIM_CHAR) begin
                r_salida  <= w_dec[7:0];
                r_err     <= w_dec[8];
                r_valid   <= 1'b1;
                r_len     <= 3'd0;
                r_pattern <= 5'd0;
                r_bad     <= 1'b0;
`ifdef MORSE_RX_WORDGAP_EN
                r_emitted <= 1'b1;
`endif
              end
              if (w_cnt_inc == LIM_WORD) begin
                r_state <= IDLE;
`ifdef MORSE_RX_WORDGAP_EN
                if (r_emitted) begin
                  r_salida  <= 8'h20;
                  r_err     <= 1'b0;
                  r_valid   <= 1'b1;
                  r_emitted <= 1'b0;
                end
`endif
              end
            end
          end

          default: begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
          end
        endcase
      end
    end
  end

  assign bus.salida = r_salida;
  assign bus.valid  = r_valid;
  assign bus.err    = r_err;

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Purpose : directed bench for morse_rx_decoder (UNIT=4) with a queue
//           scoreboard; expectations are pushed as the completing tick is
//           driven and popped by a monitor whenever valid is seen.
module tb_morse_rx_decoder;
  localparam int UNIT = 4;

  typedef struct {
    logic [7:0] ch;
    logic       e;
    int         due;
  } exp_t;

  logic CLK;
  logic RST;
  morse_rx_decoder_if bus ();

  morse_rx_decoder #(.UNIT(UNIT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  int         gate  = 1;
  logic       emitted = 1'b0;
  logic [7:0] last_ch = 8'h00;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest expectation, including cycle.
  always @(negedge CLK) begin
    exp_t x;
    if (RST === 1'b1 && bus.valid === 1'b1) begin
      chk("strobe_expected", sb.size(), (sb.size() == 0) ? 32'd1 : sb.size());
      if (sb.size() != 0) begin
        x = sb.pop_front();
        chk("salida", bus.salida, x.ch);
        chk("err", bus.err, x.e);
        chk("valid_cycle", cyc, x.due);
      end
    end
  end

  // One sample; with gating, non-tick cycles carry the opposite level.
  task automatic step(input logic v);
    for (int k = 1; k < gate; k++) begin
      @(negedge CLK);
      bus.tick     = 1'b0;
      bus.morse_in = ~v;
    end
    @(negedge CLK);
    bus.tick     = 1'b1;
    bus.morse_in = v;
  endtask

  task automatic push(input logic [7:0] ch, input logic e);
    exp_t x;
    x.ch  = ch;
    x.e   = e;
    x.due = cyc + 1;
    sb.push_back(x);
    last_ch = ch;
  endtask

  // '.'=UNIT, '-'=3*UNIT, 'L'=40, 'H'=300 tick marks; intra-char spaces UNIT.
  task automatic send(input string syms, input logic [7:0] ch, input logic e, input int gapn);
    for (int i = 0; i < syms.len(); i++) begin
      int ml;
      case (syms[i])
        "-":     ml = 3 * UNIT;
        "L":     ml = 40;
        "H":     ml = 300;
        default: ml = UNIT;
      endcase
      for (int k = 0; k < ml; k++) step(1'b1);
      if (i != syms.len() - 1)
        for (int k = 0; k < UNIT; k++) step(1'b0);
    end
    for (int k = 1; k <= gapn; k++) begin
      step(1'b0);
      if (k == 2 * UNIT) begin
        push(ch, e);
        emitted = 1'b1;
      end
      if (k == 5 * UNIT) begin
`ifdef MORSE_RX_WORDGAP_EN
        if (emitted) push(8'h20, 1'b0);
`endif
        emitted = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0);
  endtask

  initial begin
    RST          = 1'b0;
    bus.tick     = 1'b0;
    bus.morse_in = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_salida", bus.salida, 8'h00);
    chk("rst_valid", bus.valid, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    RST = 1'b1;

    // Consecutive ticks.
    gate = 1;
    send(".-",     8'h41, 1'b0, 8);   // A
    send(".",      8'h45, 1'b0, 8);   // E
    send("-----",  8'h30, 1'b0, 20);  // 0, then word gap
    idle(20);                          // no second space
    send("......", 8'h3F, 1'b1, 8);   // six symbols
    send("-",      8'h54, 1'b0, 20);  // T
    send("L",      8'h3F, 1'b1, 20);  // over-long mark
    send(".-",     8'h41, 1'b0, 20);  // A with full word gap
    idle(20);
    send("--..",   8'h5A, 1'b0, 8);   // Z
    send("....-",  8'h34, 1'b0, 20);  // 4
    idle(8);
    chk("drain_fast", sb.size(), 0);
    chk("hold_fast", bus.salida, last_ch);

    // Tick gated 1-in-3, same tick counts.
    gate = 3;
    send(".-",     8'h41, 1'b0, 8);
    send("L",      8'h3F, 1'b1, 20);
    send("......", 8'h3F, 1'b1, 8);
    send("-",      8'h54, 1'b0, 20);
    idle(8);
    chk("drain_gated", sb.size(), 0);

    // Held mark saturates; exactly one '?'.
    gate = 1;
    send("H",      8'h3F, 1'b1, 20);
    idle(8);
    chk("drain_held", sb.size(), 0);
    chk("hold_held", bus.salida, 8'h3F);

    // Reset mid-character after two dots.
    for (int k = 0; k < UNIT; k++) step(1'b1);
    for (int k = 0; k < UNIT; k++) step(1'b0);
    for (int k = 0; k < UNIT; k++) step(1'b1);
    step(1'b0);
    step(1'b0);
    @(negedge CLK);
    bus.tick = 1'b0;
    #2 RST = 1'b0;
    #1;
    chk("arst_salida", bus.salida, 8'h00);
    chk("arst_valid", bus.valid, 1'b0);
    chk("arst_err", bus.err, 1'b0);
    emitted = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    idle(10);
    chk("no_emit_after_rst", sb.size(), 0);
    send(".",      8'h45, 1'b0, 20);  // E, not S
    idle(10);
    bus.tick = 1'b0;
    repeat (4) @(negedge CLK);
    chk("drain_final", sb.size(), 0);
    chk("hold_final", bus.salida, last_ch);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
